// File: rtl/remap_speed_ctrl.sv
// 65816 accelerator remap decoder, paged-ROM shadow and CPU clock-source sequencer.
// Fully synchronous to hsclk; all outputs except reg_rdata_o/cyc_ready_o are registered.
module remap_speed_ctrl #(
  parameter int unsigned NUM_WIN = 4,
  parameter int unsigned PAGEREG_SZ = 4,
  parameter logic [PAGEREG_SZ-1:0] ROM_SLOT = {PAGEREG_SZ{1'b1}},
  parameter logic [7:0] REMAP_BANK = 8'hFE,
  parameter logic [15:0] PAGEREG_ADDR = 16'hFE30,
  parameter int unsigned HS_HOLD_CYC = 2
) (
  input  logic        hsclk_i,
  input  logic        rst_i,
  input  logic        cyc_valid_i,
  input  logic [7:0]  cpu_bank_i,
  input  logic [15:0] cpu_addr_i,
  input  logic        vda_i,
  input  logic        vpa_i,
  input  logic        rnw_i,
  input  logic        bus_wdata_stb_i,
  input  logic [7:0]  bus_wdata_i,
  input  logic        lsclk_edge_i,
  input  logic        reg_wen_i,
  input  logic [3:0]  reg_sel_i,
  input  logic [7:0]  reg_wdata_i,
  output logic [7:0]  reg_rdata_o,
  output logic [7:0]  bank_out_o,
  output logic        remap_hit_o,
  output logic        dummy_access_o,
  output logic        hsclk_sel_o,
  output logic        cyc_ready_o
);

  localparam int HW = (HS_HOLD_CYC < 1) ? 1 : $clog2(HS_HOLD_CYC + 1);

  typedef enum logic [1:0] {
    SLOW, TO_FAST, FAST, TO_SLOW
  } st_e;

  st_e                   state_q, state_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [PAGEREG_SZ-1:0] pagereg_q, pagereg_d;
  logic [7:0]            win_q [NUM_WIN];
  logic [7:0]            win_d [NUM_WIN];
  logic                  snoop_q, snoop_d;
  logic [7:0]            bank_q, bank_d;
  logic                  hit_q, hit_d;
  logic                  dummy_q, dummy_d;
  logic                  hsel_q, hsel_d;
  logic [HW-1:0]         hold_q, hold_d;

  logic       acc, win_hit, hit_cyc, snoop_cyc;
  logic       req_fast, req_slow, fast_drop;
  logic       wr_ctrl, wr_page;
  logic [7:0] eb;

  assign cyc_ready_o    = (state_q == SLOW) || (state_q == FAST);
  assign acc            = cyc_valid_i && cyc_ready_o;
  assign hsclk_sel_o    = hsel_q;
  assign bank_out_o     = bank_q;
  assign remap_hit_o    = hit_q;
  assign dummy_access_o = dummy_q;

  assign wr_ctrl = reg_wen_i && (reg_sel_i == 4'd0);
  assign wr_page = reg_wen_i && (reg_sel_i == 4'd1);

  always_comb begin
    win_hit = 1'b0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (win_q[i][7] && (win_q[i][3:0] == cpu_addr_i[15:12]) &&
          (!win_q[i][6] || (pagereg_q == ROM_SLOT)))
        win_hit = 1'b1;
    end
  end

  assign hit_cyc = !cpu_bank_i[7] && ctrl_q[0] &&
                   (vda_i || vpa_i) && win_hit;
  assign eb = hit_cyc ? REMAP_BANK : cpu_bank_i;

  assign snoop_cyc = vda_i && !rnw_i && !cpu_bank_i[7] &&
                     (cpu_addr_i == PAGEREG_ADDR);

  // Idle cycles (vda=vpa=0) never move the speed FSM.
  assign req_fast  = ctrl_q[1] && vpa_i && vda_i && rnw_i && eb[7];
  assign req_slow  = (vda_i || vpa_i) && (!eb[7] || !ctrl_q[1]);
  assign fast_drop = wr_ctrl && !reg_wdata_i[1] && ctrl_q[1];

  always_comb begin
    reg_rdata_o = '0;
    if (reg_sel_i == 4'd0) begin
      reg_rdata_o = {6'd0, ctrl_q};
    end else if (reg_sel_i == 4'd1) begin
      reg_rdata_o[PAGEREG_SZ-1:0] = pagereg_q;
    end else begin
      for (int i = 0; i < NUM_WIN; i++)
        if ({28'd0, reg_sel_i} == 32'(i + 2))
          reg_rdata_o = win_q[i];
    end
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    pagereg_d = pagereg_q;
    snoop_d   = snoop_q;
    bank_d    = bank_q;
    hit_d     = hit_q;
    dummy_d   = dummy_q;
    for (int i = 0; i < NUM_WIN; i++) begin
      win_d[i] = win_q[i];
      if (reg_wen_i && ({28'd0, reg_sel_i} == 32'(i + 2)))
        win_d[i] = reg_wdata_i & 8'hCF;
    end
    if (wr_ctrl)
      ctrl_d = reg_wdata_i[1:0];
    if (bus_wdata_stb_i && snoop_q) begin
      pagereg_d = bus_wdata_i[PAGEREG_SZ-1:0];
      snoop_d   = 1'b0;
    end
    if (acc) begin
      snoop_d = snoop_cyc;
      bank_d  = eb;
      hit_d   = hit_cyc;
      dummy_d = cpu_bank_i[7];
    end
    if (wr_page)
      pagereg_d = reg_wdata_i[PAGEREG_SZ-1:0];
  end

  always_comb begin
    state_d = state_q;
    hsel_d  = hsel_q;
    hold_d  = hold_q;
    unique case (state_q)
      SLOW: if (acc && req_fast) state_d = TO_FAST;
      TO_FAST: begin
        state_d = FAST;
        hsel_d  = 1'b1;
        hold_d  = HW'(HS_HOLD_CYC);
      end
      FAST: begin
        if (acc) begin
          if (req_slow && (hold_q == '0)) state_d = TO_SLOW;
          else if (hold_q != '0) hold_d = hold_q - 1'b1;
        end
      end
      TO_SLOW: begin
        // Source drops on the phi0 edge; ready returns a clock later.
        if (lsclk_edge_i) hsel_d = 1'b0;
        if (!hsel_q) state_d = SLOW;
      end
      default: state_d = SLOW;
    endcase
    if (fast_drop && ((state_q == FAST) || (state_q == TO_FAST))) begin
      state_d = TO_SLOW;
      hsel_d  = hsel_q;
    end
  end

  always_ff @(posedge hsclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SLOW;
      ctrl_q    <= '0;
      pagereg_q <= '0;
      snoop_q   <= 1'b0;
      bank_q    <= '0;
      hit_q     <= 1'b0;
      dummy_q   <= 1'b0;
      hsel_q    <= 1'b0;
      hold_q    <= '0;
      for (int i = 0; i < NUM_WIN; i++) win_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      pagereg_q <= pagereg_d;
      snoop_q   <= snoop_d;
      bank_q    <= bank_d;
      hit_q     <= hit_d;
      dummy_q   <= dummy_d;
      hsel_q    <= hsel_d;
      hold_q    <= hold_d;
      for (int i = 0; i < NUM_WIN; i++) win_q[i] <= win_d[i];
    end
  end

endmodule

// File: tb/tb_remap_speed_ctrl.sv
// Directed bench for remap_speed_ctrl: decode, snoop, speed sequencing, reset.
// Inputs change 1ns after hsclk rises; outputs are checked there too.
module tb_remap_speed_ctrl;

  logic        hsclk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc_valid = 1'b0;
  logic [7:0]  cpu_bank = '0;
  logic [15:0] cpu_addr = '0;
  logic        vda = 1'b0, vpa = 1'b0, rnw = 1'b1;
  logic        bus_wdata_stb = 1'b0;
  logic [7:0]  bus_wdata = '0;
  logic        lsclk_edge = 1'b0;
  logic        reg_wen = 1'b0;
  logic [3:0]  reg_sel = '0;
  logic [7:0]  reg_wdata = '0;
  logic [7:0]  reg_rdata, bank_out;
  logic        remap_hit, dummy_access, hsclk_sel, cyc_ready;

  int total = 0;
  int bad = 0;

  always #5 hsclk = ~hsclk;

  remap_speed_ctrl dut (
    .hsclk_i(hsclk), .rst_i(rst),
    .cyc_valid_i(cyc_valid), .cpu_bank_i(cpu_bank),
    .cpu_addr_i(cpu_addr), .vda_i(vda), .vpa_i(vpa),
    .rnw_i(rnw), .bus_wdata_stb_i(bus_wdata_stb),
    .bus_wdata_i(bus_wdata), .lsclk_edge_i(lsclk_edge),
    .reg_wen_i(reg_wen), .reg_sel_i(reg_sel),
    .reg_wdata_i(reg_wdata), .reg_rdata_o(reg_rdata),
    .bank_out_o(bank_out), .remap_hit_o(remap_hit),
    .dummy_access_o(dummy_access), .hsclk_sel_o(hsclk_sel),
    .cyc_ready_o(cyc_ready)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hsclk);
    #1;
  endtask

  task automatic wr(input logic [3:0] s, input logic [7:0] d);
    reg_wen = 1'b1; reg_sel = s; reg_wdata = d;
    tick();
    reg_wen = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] s,
                    input logic [7:0] exp);
    reg_sel = s;
    #1;
    chk(tag, {8'd0, reg_rdata}, {8'd0, exp});
  endtask

  task automatic cyc(input logic [7:0] b, input logic [15:0] a,
                     input logic d, input logic p, input logic r);
    chk("ready_at_cyc", {15'd0, cyc_ready}, 16'd1);
    cpu_bank = b; cpu_addr = a; vda = d; vpa = p; rnw = r;
    cyc_valid = 1'b1;
    tick();
    cyc_valid = 1'b0; vda = 1'b0; vpa = 1'b0; rnw = 1'b1;
  endtask

  task automatic outs(input string tag, input logic [7:0] b,
                      input logic h, input logic dm);
    chk({tag, "_bank"}, {8'd0, bank_out}, {8'd0, b});
    chk({tag, "_hit"}, {15'd0, remap_hit}, {15'd0, h});
    chk({tag, "_dummy"}, {15'd0, dummy_access}, {15'd0, dm});
  endtask

  task automatic spd(input string tag, input logic hs, input logic rdy);
    chk({tag, "_hsel"}, {15'd0, hsclk_sel}, {15'd0, hs});
    chk({tag, "_ready"}, {15'd0, cyc_ready}, {15'd0, rdy});
  endtask

  initial begin
    tick(); tick();
    outs("rst", 8'h00, 1'b0, 1'b0);
    spd("rst", 1'b0, 1'b1);
    rst = 1'b0;
    tick();

    for (int s = 0; s <= 6; s++) rd("rd_zero", 4'(s), 8'h00);
    rd("rd_zero15", 4'd15, 8'h00);

    wr(4'd2, 8'h8C);
    wr(4'd0, 8'h01);
    wr(4'd9, 8'hFF);
    rd("rd_win0", 4'd2, 8'h8C);
    rd("rd_ctrl", 4'd0, 8'h01);
    rd("rd_unimpl", 4'd9, 8'h00);

    cyc(8'h00, 16'hC123, 1'b1, 1'b0, 1'b1);
    outs("remap_c123", 8'hFE, 1'b1, 1'b0);
    spd("remap_c123", 1'b0, 1'b1);
    tick(); tick();
    outs("held_c123", 8'hFE, 1'b1, 1'b0);
    cyc(8'h00, 16'h5123, 1'b1, 1'b0, 1'b1);
    outs("miss_5123", 8'h00, 1'b0, 1'b0);
    cyc(8'h80, 16'hC123, 1'b1, 1'b0, 1'b1);
    outs("hibank", 8'h80, 1'b0, 1'b1);
    cyc(8'h00, 16'hC123, 1'b0, 1'b0, 1'b1);
    outs("idle_c123", 8'h00, 1'b0, 1'b0);

    wr(4'd3, 8'hC8);
    wr(4'd1, 8'h03);
    cyc(8'h00, 16'h8000, 1'b1, 1'b0, 1'b1);
    outs("romq_off", 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 16'hFE30, 1'b1, 1'b0, 1'b0);
    bus_wdata = 8'h0F; bus_wdata_stb = 1'b1;
    tick();
    bus_wdata_stb = 1'b0;
    rd("snoop_load", 4'd1, 8'h0F);
    cyc(8'h00, 16'h8000, 1'b1, 1'b0, 1'b1);
    outs("romq_on", 8'hFE, 1'b1, 1'b0);

    cyc(8'h00, 16'hFE30, 1'b1, 1'b0, 1'b0);
    cyc(8'h00, 16'h1000, 1'b1, 1'b0, 1'b1);
    bus_wdata = 8'h03; bus_wdata_stb = 1'b1;
    tick();
    bus_wdata_stb = 1'b0;
    rd("snoop_cleared", 4'd1, 8'h0F);

    cyc(8'h00, 16'hFE30, 1'b1, 1'b0, 1'b0);
    bus_wdata = 8'h05; bus_wdata_stb = 1'b1;
    reg_wen = 1'b1; reg_sel = 4'd1; reg_wdata = 8'h09;
    tick();
    bus_wdata_stb = 1'b0; reg_wen = 1'b0;
    rd("regwr_wins", 4'd1, 8'h09);

    wr(4'd0, 8'h03);
    cyc(8'hFE, 16'h0000, 1'b1, 1'b1, 1'b1);
    outs("fetch_fe", 8'hFE, 1'b0, 1'b1);
    spd("to_fast", 1'b0, 1'b0);
    tick();
    spd("fast", 1'b1, 1'b1);
    cyc(8'hFE, 16'h0001, 1'b1, 1'b1, 1'b1);
    spd("fast_f1", 1'b1, 1'b1);
    cyc(8'hFE, 16'h0002, 1'b1, 1'b1, 1'b1);
    spd("fast_f2", 1'b1, 1'b1);
    cyc(8'h00, 16'h0100, 1'b1, 1'b0, 1'b1);
    outs("bbc_rd", 8'h00, 1'b0, 1'b0);
    spd("to_slow", 1'b1, 1'b0);
    tick(); tick();
    spd("to_slow_wait", 1'b1, 1'b0);
    lsclk_edge = 1'b1;
    tick();
    lsclk_edge = 1'b0;
    spd("ls_edge", 1'b0, 1'b0);
    tick();
    spd("slow_again", 1'b0, 1'b1);

    cyc(8'hFE, 16'h0010, 1'b1, 1'b1, 1'b1);
    spd("to_fast2", 1'b0, 1'b0);
    tick();
    spd("fast2", 1'b1, 1'b1);
    cyc(8'h00, 16'h0100, 1'b1, 1'b0, 1'b1);
    spd("hold_stays", 1'b1, 1'b1);
    wr(4'd0, 8'h01);
    spd("forced_slow", 1'b1, 1'b0);
    rd("ctrl_nofast", 4'd0, 8'h01);

    rst = 1'b1;
    #1;
    spd("rst_mid", 1'b0, 1'b1);
    outs("rst_mid", 8'h00, 1'b0, 1'b0);
    rd("rst_ctrl", 4'd0, 8'h00);
    rd("rst_page", 4'd1, 8'h00);
    rd("rst_win0", 4'd2, 8'h00);
    rd("rst_win1", 4'd3, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    spd("post_rst", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
